reg_fifo: RTL
=============

Name: reg_fifo

Overview:
Parametrised successor to the single load-enabled signed data register. It generalises one register into a DEPTH-entry first-word-fall-through (FWFT) buffer of signed WIDTH-bit words, with push/pop handshake, occupancy count, full/empty flags and sticky error flags. It sits between LBM datapath stages, such as collision output and streaming input, and absorbs rate mismatch between producer and consumer. It uses one clock domain.

Parameters:
WIDTH, 64, data word width in bits (signed)
DEPTH, 8, number of storage entries; any integer >= 2; need not be a power of two
CW, $clog2(DEPTH+1), width of Count (derived; not overridden)

Ports:
Clk  input  1  system clock; all state changes on the rising edge
Reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately
Clear  input  1  synchronous flush, active-high
LD_EN  input  1  push request; writes Data_In when accepted
RD_EN  input  1  pop request; advances the head when accepted
Data_In  input  WIDTH  signed write data
Data_Out  output  WIDTH  signed head-of-queue word (FWFT)
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Count  output  CW  number of stored words, 0..DEPTH
Overflow  output  1  sticky; a push was rejected
Underflow  output  1  sticky; a pop was rejected

Behaviour:
- Reset low (async): wr_ptr = rd_ptr = 0, Count = 0, Empty = 1, Full = 0, Overflow = 0, Underflow = 0, Data_Out = 0. Storage array is not reset. On release, the block operates from the next rising edge.
- Acceptance, evaluated on pre-edge state:
  - push_ok = LD_EN & (!Full | RD_EN)
  - pop_ok = RD_EN & !Empty
- Push: mem[wr_ptr] <= Data_In; wr_ptr advances.
- Pop: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0, otherwise +1. This explicit compare is required because DEPTH need not be a power of two.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged on both or neither.
- Full/Empty: derived combinationally from Count; no separate state.
- Data_Out: combinational mem[rd_ptr] when !Empty, forced to 0 when Empty. Latency from push into an empty FIFO to valid Data_Out is 1 clock, i.e. visible after the write edge.
- Simultaneous push and pop while full: both accepted; the pop frees the slot. Count stays DEPTH; the new word lands in the old head slot while rd_ptr moves on.
- Simultaneous push and pop while empty: push accepted, pop rejected. Underflow is set and Count becomes 1. There is no bypass: Data_In is never forwarded combinationally.
- Rejected push (LD_EN & Full & !RD_EN): storage unchanged; Overflow <= 1.
- Rejected pop (RD_EN & Empty): Underflow <= 1.
- Sticky flags are cleared only by Reset or Clear.
- Clear: on the next edge, pointers, Count and both sticky flags go to 0. Clear has priority over any same-cycle push or pop, which are dropped without setting error flags.
- Reset asserted mid-operation: contents are discarded, equivalent to the reset state. Old array data must never reappear on Data_Out, because Empty forces Data_Out to 0.
- Arithmetic: data passes through unmodified with no sign extension. Count is unsigned.

Decomposition:
- Package reg_pkg:
  - localparam DEFAULT_WIDTH = 64
  - typedef for the signed data word, parametrised via a class-free typedef in the user module
  - function next_ptr(ptr, depth) for wrap logic, shared with future ring buffers
- Sub-module wrap_counter (parameters MAX and W; ports Clk, Reset, Clear, inc, value), instanced twice for wr_ptr and rd_ptr.

Test Plan:
- Reset and flags: hold Reset low, then release with no requests -> Empty = 1, Full = 0, Count = 0, Data_Out = 0; Reset low mid-stream -> all outputs return to these values immediately, without waiting for a clock.
- Fill to full: DEPTH = 8; push 64'h1234_5678_0000_0000 + i for i = 0..7 -> Count steps 1..8, Full = 1 after 8th edge, Data_Out = 64'h1234_5678_0000_0000 from 1 clock after the first push.
- Overflow: while full, push 64'hDEAD -> Count stays 8, Overflow = 1; pop all 8 -> values emerge in order 0..7, Empty = 1, Overflow still 1.
- Underflow and empty-case simultaneity: pop with Empty -> Underflow = 1, Count 0; push -5 with RD_EN = 1 on empty -> Count = 1, Data_Out = -5 (64'hFFFF_FFFF_FFFF_FFFB).
- Full-case simultaneity and wrap: DEPTH = 5, full with 1..5; push 6 and pop together three times -> Count stays 5; draining gives 4, 5, 6, 7, 8, exercising pointer wrap past index 4.
- Clear priority: Count = 3, Overflow = 1; assert Clear with LD_EN = 1 and RD_EN = 1 -> next edge Count = 0, Empty = 1, Overflow = 0, Underflow = 0, Data_Out = 0.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared definitions for the register FIFO family: default word width and
// the ring-buffer pointer wrap helper.
package reg_pkg;

  localparam int DEFAULT_WIDTH = 64;

  typedef logic signed [DEFAULT_WIDTH-1:0] default_word_t;

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-MAX pointer register with synchronous clear, used for the FIFO
// read and write pointers.
module wrap_counter
  import reg_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (Clear) begin
      value_d = '0;
    end else if (inc) begin
      value_d = W'(next_ptr(32'(value_q), 32'(MAX)));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/reg_fifo.sv
// DEPTH-entry first-word-fall-through buffer of signed words with occupancy
// count, full/empty flags and sticky overflow/underflow flags.
module reg_fifo
  import reg_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Clear,
  input  logic                    LD_EN,
  input  logic                    RD_EN,
  input  logic signed [WIDTH-1:0] Data_In,
  output logic signed [WIDTH-1:0] Data_Out,
  output logic                    Full,
  output logic                    Empty,
  output logic [CW-1:0]           Count,
  output logic                    Overflow,
  output logic                    Underflow
);

  localparam int PW = $clog2(DEPTH);

  typedef logic signed [WIDTH-1:0] word_t;

  word_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          push_ok, pop_ok;

  assign Full  = (count_q == CW'(DEPTH));
  assign Empty = (count_q == '0);

  // A pop frees the head slot in the same edge, so a full FIFO still takes a push.
  assign push_ok = LD_EN & (~Full | RD_EN);
  assign pop_ok  = RD_EN & ~Empty;

  wrap_counter #(
    .MAX (DEPTH),
    .W   (PW)
  ) u_wr_ptr (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (Clear),
    .inc   (push_ok),
    .value (wr_ptr)
  );

  wrap_counter #(
    .MAX (DEPTH),
    .W   (PW)
  ) u_rd_ptr (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (Clear),
    .inc   (pop_ok),
    .value (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (Clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (push_ok && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - CW'(1);
      end
      if (LD_EN && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (RD_EN && !pop_ok) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset; Empty masks stale contents.
  always_ff @(posedge Clk) begin
    if (push_ok && !Clear) begin
      mem[wr_ptr] <= Data_In;
    end
  end

  assign Data_Out  = Empty ? '0 : mem[rd_ptr];
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule
